// File: rtl/boxcar_trig_pkg.sv
// Shared definitions for the boxcar sum / threshold trigger.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package boxcar_trig_pkg;

  // Trigger FSM encodings, kept as plain constants so legacy tools and
  // downstream register maps see fixed 2-bit codes.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_ABOVE = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  // Default widths, matching the RAM delay line this block follows.
  localparam int DEF_NBITS_DATA = 14;
  localparam int DEF_NBITS_ADDR = 8;
  localparam int DEF_NBITS_HOLD = 16;

  // A window of up to 2^addr samples of data bits each fits in data+addr bits.
  function automatic int sum_width(input int nbits_data, input int nbits_addr);
    return nbits_data + nbits_addr;
  endfunction

endpackage

// File: rtl/boxcar_trig_sat_accum.sv
// Window update base + add - sub, evaluated signed one bit wider, clamped at 0.
// Latency: combinational.
// Backpressure: none; caller decides when the result is captured.
module sat_accum #(
  parameter int P_NBITS_DATA = 14,
  parameter int P_NBITS_SUM  = 22
) (
  input  logic [P_NBITS_SUM-1:0]  base,
  input  logic [P_NBITS_DATA-1:0] add,
  input  logic [P_NBITS_DATA-1:0] sub,
  input  logic                    sub_en,
  output logic [P_NBITS_SUM-1:0]  res,
  output logic                    neg
);

  localparam int W = P_NBITS_SUM + 1;

  logic signed [W-1:0] base_s;
  logic signed [W-1:0] add_s;
  logic signed [W-1:0] sub_s;
  logic signed [W-1:0] diff_s;

  // Unsigned operands are zero-extended into the wider signed domain so the
  // sign bit of the difference flags an inconsistent (negative) window.
  always_comb begin
    base_s = {1'b0, base};
    add_s  = W'(add);
    sub_s  = sub_en ? W'(sub) : '0;
    diff_s = base_s + add_s - sub_s;
    neg    = diff_s[W-1];
    res    = neg ? '0 : diff_s[P_NBITS_SUM-1:0];
  end

endmodule

// File: rtl/boxcar_trig.sv
// Running n-sample sum fed by the delay line, with a hysteresis trigger and peak tracker.
// Latency: 1 clk from a wr cycle to updated sum/state/pulse outputs.
// Backpressure: none; accepts one sample per clk, idle cycles (wr=0) freeze all state.
module boxcar_trig
  import boxcar_trig_pkg::*;
#(
  parameter int P_NBITS_DATA = DEF_NBITS_DATA,
  parameter int P_NBITS_ADDR = DEF_NBITS_ADDR,
  parameter int P_NBITS_SUM  = sum_width(P_NBITS_DATA, P_NBITS_ADDR),
  parameter int P_NBITS_HOLD = DEF_NBITS_HOLD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    wr,
  input  logic                    valid,
  input  logic [P_NBITS_DATA-1:0] qo,
  input  logic [P_NBITS_DATA-1:0] qn,
  input  logic [P_NBITS_SUM-1:0]  thresh_hi,
  input  logic [P_NBITS_SUM-1:0]  thresh_lo,
  input  logic [P_NBITS_HOLD-1:0] holdoff,
  output logic [P_NBITS_SUM-1:0]  sum,
  output logic                    sum_valid,
  output logic                    trig,
  output logic [P_NBITS_SUM-1:0]  peak,
  output logic [P_NBITS_HOLD-1:0] peak_pos,
  output logic                    peak_valid,
  output logic                    err,
  output logic [1:0]              state
);

  logic [P_NBITS_SUM-1:0]  sum_q, sum_d;
  logic                    sum_valid_q, sum_valid_d;
  logic                    trig_q, trig_d;
  logic [P_NBITS_SUM-1:0]  peak_q, peak_d;
  logic [P_NBITS_HOLD-1:0] peak_pos_q, peak_pos_d;
  logic [P_NBITS_HOLD-1:0] pos_q, pos_d;
  logic                    peak_valid_q, peak_valid_d;
  logic                    err_q, err_d;
  logic [1:0]              state_q, state_d;
  logic [P_NBITS_HOLD-1:0] hold_q, hold_d;

  logic                    restart;
  logic [P_NBITS_SUM-1:0]  acc_base;
  logic [P_NBITS_SUM-1:0]  sum_next;
  logic                    acc_neg;
  logic [P_NBITS_HOLD-1:0] pos_inc;

  // Losing valid outside IDLE means upstream is re-priming: start a fresh
  // fill from the current sample instead of accumulating onto the old window.
  always_comb begin
    restart  = !valid && (state_q != S_IDLE);
    acc_base = restart ? '0 : sum_q;
    pos_inc  = (&pos_q) ? pos_q : pos_q + P_NBITS_HOLD'(1);
  end

  sat_accum #(
    .P_NBITS_DATA (P_NBITS_DATA),
    .P_NBITS_SUM  (P_NBITS_SUM)
  ) u_sat_accum (
    .base   (acc_base),
    .add    (qo),
    .sub    (qn),
    .sub_en (valid),
    .res    (sum_next),
    .neg    (acc_neg)
  );

  // Next-state logic: clear has priority, otherwise only wr cycles move anything.
  always_comb begin
    sum_d        = sum_q;
    sum_valid_d  = sum_valid_q;
    trig_d       = 1'b0;
    peak_d       = peak_q;
    peak_pos_d   = peak_pos_q;
    pos_d        = pos_q;
    peak_valid_d = 1'b0;
    err_d        = err_q;
    state_d      = state_q;
    hold_d       = hold_q;

    if (clr) begin
      sum_d       = '0;
      sum_valid_d = 1'b0;
      peak_d      = '0;
      peak_pos_d  = '0;
      pos_d       = '0;
      err_d       = 1'b0;
      state_d     = S_IDLE;
      hold_d      = '0;
    end else if (wr) begin
      sum_d = sum_next;
      if (acc_neg) begin
        err_d = 1'b1;
      end

      if (!valid) begin
        // Fill while IDLE; otherwise abort whatever was in flight, silently.
        if (state_q != S_IDLE) begin
          state_d     = S_IDLE;
          sum_valid_d = 1'b0;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            // First full window; thresholds are only looked at from the next wr.
            state_d     = S_ARMED;
            sum_valid_d = 1'b1;
          end

          S_ARMED: begin
            if (sum_next >= thresh_hi) begin
              state_d    = S_ABOVE;
              trig_d     = 1'b1;
              peak_d     = sum_next;
              peak_pos_d = '0;
              pos_d      = '0;
            end
          end

          S_ABOVE: begin
            pos_d = pos_inc;
            // Strict compare keeps the earliest of equal maxima.
            if (sum_next > peak_q) begin
              peak_d     = sum_next;
              peak_pos_d = pos_inc;
            end
            if (sum_next < thresh_lo) begin
              peak_valid_d = 1'b1;
              if (holdoff == '0) begin
                state_d = S_ARMED;
              end else begin
                state_d = S_HOLD;
                hold_d  = holdoff;
              end
            end
          end

          S_HOLD: begin
            if (hold_q <= P_NBITS_HOLD'(1)) begin
              hold_d  = '0;
              state_d = S_ARMED;
            end else begin
              hold_d = hold_q - P_NBITS_HOLD'(1);
            end
          end

          default: begin
            state_d = S_IDLE;
          end
        endcase
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q        <= '0;
      sum_valid_q  <= 1'b0;
      trig_q       <= 1'b0;
      peak_q       <= '0;
      peak_pos_q   <= '0;
      pos_q        <= '0;
      peak_valid_q <= 1'b0;
      err_q        <= 1'b0;
      state_q      <= S_IDLE;
      hold_q       <= '0;
    end else begin
      sum_q        <= sum_d;
      sum_valid_q  <= sum_valid_d;
      trig_q       <= trig_d;
      peak_q       <= peak_d;
      peak_pos_q   <= peak_pos_d;
      pos_q        <= pos_d;
      peak_valid_q <= peak_valid_d;
      err_q        <= err_d;
      state_q      <= state_d;
      hold_q       <= hold_d;
    end
  end

  assign sum        = sum_q;
  assign sum_valid  = sum_valid_q;
  assign trig       = trig_q;
  assign peak       = peak_q;
  assign peak_pos   = peak_pos_q;
  assign peak_valid = peak_valid_q;
  assign err        = err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_boxcar_trig.sv
// Randomized bench for boxcar_trig with a window-history reference model.
// Latency: expects outputs one clk after each driven cycle.
// Backpressure: none; drives up to one sample per clk with random idle gaps.
module tb_boxcar_trig;

  localparam int ND = 14;
  localparam int NA = 8;
  localparam int NS = ND + NA;
  localparam int NH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          wr = 1'b0;
  logic          valid = 1'b0;
  logic [ND-1:0] qo = '0;
  logic [ND-1:0] qn = '0;
  logic [NS-1:0] thresh_hi = '0;
  logic [NS-1:0] thresh_lo = '0;
  logic [NH-1:0] holdoff = '0;
  logic [NS-1:0] sum;
  logic          sum_valid;
  logic          trig;
  logic [NS-1:0] peak;
  logic [NH-1:0] peak_pos;
  logic          peak_valid;
  logic          err;
  logic [1:0]    state;

  boxcar_trig #(
    .P_NBITS_DATA (ND),
    .P_NBITS_ADDR (NA),
    .P_NBITS_SUM  (NS),
    .P_NBITS_HOLD (NH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .wr         (wr),
    .valid      (valid),
    .qo         (qo),
    .qn         (qn),
    .thresh_hi  (thresh_hi),
    .thresh_lo  (thresh_lo),
    .holdoff    (holdoff),
    .sum        (sum),
    .sum_valid  (sum_valid),
    .trig       (trig),
    .peak       (peak),
    .peak_pos   (peak_pos),
    .peak_valid (peak_valid),
    .err        (err),
    .state      (state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Configuration seen by both the emulated upstream and the model.
  int n_win  = 4;
  int th_hi  = 500;
  int th_lo  = 300;
  int hold_v = 3;

  // Model: samples since the last (re)start of the delay line, plus the
  // samples seen while a pulse is in progress.
  int m_hist[$];
  int m_pulse[$];
  int m_sum, m_peak, m_ppos, m_mode, m_hold;
  bit m_sv, m_trig, m_pv, m_err;

  // Values the DUT must show after the most recent clock edge.
  int e_sum, e_peak, e_ppos, e_mode;
  bit e_sv, e_trig, e_pv, e_err;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_cfg(input int n, input int hi, input int lo, input int h);
    n_win = n; th_hi = hi; th_lo = lo; hold_v = h;
    thresh_hi = NS'(hi);
    thresh_lo = NS'(lo);
    holdoff   = NH'(h);
  endtask

  task automatic model_reset();
    m_hist.delete();
    m_pulse.delete();
    m_sum = 0; m_peak = 0; m_ppos = 0; m_mode = 0; m_hold = 0;
    m_sv = 0; m_trig = 0; m_pv = 0; m_err = 0;
  endtask

  task automatic set_exp();
    e_sum = m_sum; e_peak = m_peak; e_ppos = m_ppos; e_mode = m_mode;
    e_sv = m_sv; e_trig = m_trig; e_pv = m_pv; e_err = m_err;
  endtask

  task automatic tick();
    @(posedge clk);
    set_exp();
    #1;
  endtask

  // Trigger behaviour on one accepted sample, given the new window sum m_sum.
  task automatic model_fsm(input bit v);
    int best;
    if (!v) begin
      if (m_mode != 0) begin
        m_mode = 0;
        m_sv = 0;
        m_pulse.delete();
      end
    end else begin
      case (m_mode)
        0: begin m_mode = 1; m_sv = 1; end
        1: if (m_sum >= th_hi) begin
             m_mode = 2; m_trig = 1;
             m_pulse.delete();
             m_pulse.push_back(m_sum);
             m_peak = m_sum; m_ppos = 0;
           end
        2: begin
             m_pulse.push_back(m_sum);
             best = 0;
             foreach (m_pulse[i]) if (m_pulse[i] > m_pulse[best]) best = i;
             m_peak = m_pulse[best];
             m_ppos = (best > 65535) ? 65535 : best;
             if (m_sum < th_lo) begin
               m_pv = 1;
               if (hold_v == 0) m_mode = 1;
               else begin m_mode = 3; m_hold = hold_v; end
             end
           end
        default: begin
             m_hold--;
             if (m_hold == 0) m_mode = 1;
           end
      endcase
    end
  endtask

  // Emulated delay line feeding one sample; drop=1 models upstream re-priming.
  task automatic sample(input int x, input bit drop);
    int k, lo;
    int acc;
    wr = 1'b1; clr = 1'b0; qo = ND'(x);
    m_trig = 0; m_pv = 0;
    if (drop) begin
      valid = 1'b0;
      qn = ND'($urandom);
      m_hist.delete();
    end else begin
      k = m_hist.size();
      valid = (k >= n_win);
      qn = valid ? ND'(m_hist[k - n_win]) : ND'($urandom);
    end
    m_hist.push_back(x);
    lo = valid ? (m_hist.size() - n_win) : 0;
    acc = 0;
    for (int i = lo; i < m_hist.size(); i++) acc += m_hist[i];
    m_sum = acc;
    model_fsm(valid);
    tick();
  endtask

  task automatic idle_cycle();
    wr = 1'b0; clr = 1'b0;
    valid = 1'($urandom_range(0, 1));
    qo = ND'($urandom); qn = ND'($urandom);
    m_trig = 0; m_pv = 0;
    tick();
  endtask

  task automatic clr_cycle(input bit with_wr);
    clr = 1'b1; wr = with_wr; valid = 1'b1;
    qo = ND'($urandom); qn = ND'($urandom);
    model_reset();
    tick();
    clr = 1'b0; wr = 1'b0;
  endtask

  task automatic chk_all_reset(input string tag);
    chk({tag, ".sum"}, sum, 0);
    chk({tag, ".sum_valid"}, sum_valid, 0);
    chk({tag, ".trig"}, trig, 0);
    chk({tag, ".peak"}, peak, 0);
    chk({tag, ".peak_pos"}, peak_pos, 0);
    chk({tag, ".peak_valid"}, peak_valid, 0);
    chk({tag, ".err"}, err, 0);
    chk({tag, ".state"}, state, 0);
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc.sum", sum, e_sum);
      chk("cyc.sum_valid", sum_valid, e_sv);
      chk("cyc.trig", trig, e_trig);
      chk("cyc.peak", peak, e_peak);
      chk("cyc.peak_pos", peak_pos, e_ppos);
      chk("cyc.peak_valid", peak_valid, e_pv);
      chk("cyc.err", err, e_err);
      chk("cyc.state", state, e_mode);
    end
  end

  initial begin
    int r;
    set_cfg(4, 500, 300, 3);
    model_reset();
    set_exp();
    repeat (2) @(posedge clk);
    #1;
    chk_all_reset("rst");
    rst = 1'b0;
    chk_en = 1'b1;

    // Fill and steady state, n=4, constant 100.
    repeat (4) sample(100, 0);
    chk("fill.sum_valid_low", sum_valid, 0);
    chk("fill.sum", sum, 400);
    sample(100, 0);
    chk("steady.sum", sum, 400);
    chk("steady.sum_valid", sum_valid, 1);
    chk("steady.state", state, 1);
    repeat (6) begin
      sample(100, 0);
      chk("steady.no_trig", trig, 0);
    end
    chk("steady.sum_end", sum, 400);

    // Single pulse, n=2: sums 400,520,640,600,280.
    set_cfg(2, 500, 300, 3);
    clr_cycle(0);
    sample(200, 0); sample(200, 0); sample(200, 0);
    chk("pulse.armed_sum", sum, 400);
    sample(320, 0);
    chk("pulse.trig", trig, 1);
    chk("pulse.trig_sum", sum, 520);
    chk("pulse.above", state, 2);
    sample(320, 0);
    chk("pulse.no_retrig", trig, 0);
    sample(280, 0);
    sample(0, 0);
    chk("pulse.release_sum", sum, 280);
    chk("pulse.peak_valid", peak_valid, 1);
    chk("pulse.peak", peak, 640);
    chk("pulse.peak_pos", peak_pos, 1);
    chk("pulse.hold", state, 3);

    // Holdoff: re-crossings during hold are ignored.
    sample(320, 0);
    chk("hold.1", state, 3);
    sample(320, 0);
    chk("hold.2_sum", sum, 640);
    chk("hold.2_no_trig", trig, 0);
    chk("hold.2", state, 3);
    sample(320, 0);
    chk("hold.3_armed", state, 1);
    chk("hold.3_no_trig", trig, 0);
    sample(320, 0);
    chk("rearm.trig", trig, 1);

    // Holdoff of zero returns straight to ARMED.
    set_cfg(2, 500, 300, 0);
    sample(0, 0);
    chk("h0.still_above", state, 2);
    sample(0, 0);
    chk("h0.peak_valid", peak_valid, 1);
    chk("h0.armed", state, 1);
    sample(600, 0);
    chk("h0.retrig", trig, 1);
    chk("h0.peak", peak, 600);

    // Valid drop mid-pulse.
    sample(77, 1);
    chk("drop.sum", sum, 77);
    chk("drop.state", state, 0);
    chk("drop.no_pv", peak_valid, 0);
    chk("drop.sv", sum_valid, 0);
    sample(50, 0); sample(30, 0);
    chk("drop.refill", sum, 80);

    // Clear with a simultaneous wr discards the sample.
    clr_cycle(1);
    chk_all_reset("clr");

    // Randomized traffic.
    for (int it = 0; it < 1500; it++) begin
      r = $urandom_range(0, 99);
      if (r < 25) idle_cycle();
      else if (r < 27 && m_mode != 0) sample($urandom_range(0, 1000), 1);
      else if (r < 29) begin
        set_cfg($urandom_range(1, 8), 0, 0, $urandom_range(0, 5));
        set_cfg(n_win, n_win * $urandom_range(400, 650),
                n_win * $urandom_range(250, 550), hold_v);
        clr_cycle(1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 3) == 0) sample($urandom_range(700, 1000), 0);
      else sample($urandom_range(0, 600), 0);
    end

    // Asynchronous reset in the middle of a pulse.
    set_cfg(2, 500, 300, 3);
    clr_cycle(0);
    sample(200, 0); sample(200, 0); sample(200, 0); sample(400, 0);
    chk("arst.pre_above", state, 2);
    chk_en = 1'b0;
    wr = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_all_reset("arst");
    model_reset();
    set_exp();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (4) sample(100, 0);
    chk("arst.no_pv", peak_valid, 0);

    // Inconsistent window: negative result clamps to 0 and err sticks.
    chk_en = 1'b0;
    clr_cycle(0);
    wr = 1'b1; valid = 1'b0; qo = ND'(50); qn = '0;
    @(posedge clk); #1;
    wr = 1'b1; valid = 1'b1; qo = ND'(10); qn = ND'(100);
    @(posedge clk); #1;
    chk("err.sum", sum, 0);
    chk("err.flag", err, 1);
    wr = 1'b1; valid = 1'b1; qo = ND'(30); qn = '0;
    @(posedge clk); #1;
    chk("err.sum_after", sum, 30);
    chk("err.sticky", err, 1);
    clr_cycle(0);
    chk("err.cleared", err, 0);
    chk_en = 1'b1;
    repeat (3) idle_cycle();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/boxcar_trig.md
# boxcar_trig

Moving-window (boxcar) sum and threshold trigger that sits directly downstream of the RAM delay line. Each sample strobe it updates a running sum of the last n samples as sum + qo − qn, using the delay line's aligned current/delayed outputs. It then runs a hysteresis trigger state machine on that sum, reporting a trigger pulse, then the peak sum and its position within the pulse. A holdoff window follows each pulse.

## Interface
Parameters:
- P_NBITS_DATA, 14, sample width (unsigned), must match the delay line
- P_NBITS_ADDR, 8, delay-length width, must match the delay line
- P_NBITS_SUM, P_NBITS_DATA+P_NBITS_ADDR, running-sum width
- P_NBITS_HOLD, 16, holdoff and peak-position counter width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear of sum/state/err; driven together with the delay line's rst
- wr  in  1  sample strobe, same strobe as the delay line's write enable
- valid  in  1  delay line valid: qn is the n-sample-delayed copy of qo
- qo  in  P_NBITS_DATA  current sample
- qn  in  P_NBITS_DATA  sample n strobes earlier
- thresh_hi  in  P_NBITS_SUM  trigger (arm→above) threshold
- thresh_lo  in  P_NBITS_SUM  release (above→holdoff) threshold
- holdoff  in  P_NBITS_HOLD  strobes to wait after release
- sum  out  P_NBITS_SUM  registered running sum
- sum_valid  out  1  sum represents a full n-sample window
- trig  out  1  one-cycle pulse on threshold crossing
- peak  out  P_NBITS_SUM  maximum sum of the last pulse
- peak_pos  out  P_NBITS_HOLD  strobes from trig to peak, saturating
- peak_valid  out  1  one-cycle pulse when peak/peak_pos are final
- err  out  1  sticky: window arithmetic went negative
- state  out  2  current FSM state

## Operation
- Arithmetic: the difference is computed signed at P_NBITS_SUM+1 bits. A negative result saturates sum to 0 and sets err. Overflow is impossible for n < 2^P_NBITS_ADDR.
- sum_next, on a wr cycle:
  - valid=0 and state≠IDLE (valid dropped, upstream re-priming): sum_next = qo. The state goes to IDLE and an in-flight pulse is aborted with no peak_valid.
  - valid=0 in IDLE (fill): sum_next = sum + qo.
  - valid=1: sum_next = sum + qo − qn.
- Non-wr cycles: nothing changes and no pulse outputs fire.
- All threshold compares are unsigned and use sum_next.
- FSM states: S_IDLE=0, S_ARMED=1, S_ABOVE=2, S_HOLD=3.
  - S_IDLE: on wr with valid=1 → S_ARMED, and sum_valid is set. The threshold is evaluated on the next wr.
  - S_ARMED: sum_next ≥ thresh_hi → S_ABOVE. On entry: trig=1, peak=sum_next, peak_pos=0.
  - S_ABOVE:
    - Each wr increments peak_pos, saturating at all-ones.
    - sum_next > peak updates peak and latches the current position; ties keep the first maximum.
    - sum_next < thresh_lo → peak_valid=1. The next state is S_HOLD with counter=holdoff, or S_ARMED if holdoff=0.
    - The release check starts on the wr after entry. If thresh_lo > thresh_hi, the result is therefore a minimum one-sample pulse.
  - S_HOLD: counter decrements on each wr and → S_ARMED after the wr that reaches 0. Threshold crossings are ignored.
- clr: sum=0, state=S_IDLE, sum_valid=0, err=0, counters=0. clr wins over a simultaneous wr, and that sample is discarded.
- sum_valid clears on any transition to S_IDLE.

## Timing
- All outputs are registered. sum/state update on the clock edge after the wr cycle (latency 1).
- trig and peak_valid are high for exactly one clk and coincide with the updated sum/state.
- peak and peak_pos hold their values until the next trig.
- Reset values: sum=0, sum_valid=0, trig=0, peak=0, peak_pos=0, peak_valid=0, err=0, state=S_IDLE.
- rst mid-pulse returns to these values immediately (asynchronous) and emits no peak_valid.
- Back-to-back wr at full clock rate is supported. Throughput is one sample per clk.

## Structure
- Package boxcar_trig_pkg holds the state encodings S_IDLE..S_HOLD and the default-sum-width rule (data + addr bits).
- One sub-module is natural: sat_accum, the signed add/subtract with saturate-to-zero and the err flag. It is instantiated once.
- The FSM, holdoff counter, and peak tracker stay in boxcar_trig.

## Test plan
- Fill and steady state: n=4 upstream, constant qo=100 → sum reaches 400 with sum_valid=1 after valid rises. It then stays 400 and trig never fires with thresh_hi=500.
- Single pulse: thresh_hi=500, thresh_lo=300, holdoff=3. A window sum sequence 400, 520, 640, 600, 280 produces:
  - trig on the 520 sample;
  - peak_valid on the 280 sample with peak=640, peak_pos=1;
  - S_HOLD for 3 wr, then S_ARMED.
- Holdoff suppression: a second crossing during S_HOLD → no trig. With holdoff=0 → direct return to S_ARMED, and an immediate re-crossing triggers.
- Valid drop mid-pulse: deassert valid during S_ABOVE → state=S_IDLE, sum=qo, no peak_valid.
- Reset and clear: asserting rst asynchronously mid-pulse, and asserting clr together with wr, both give all outputs at reset values. The wr sample is ignored.
- Inconsistency: qn > sum + qo → sum=0, err=1 (sticky until clr).
